// File: rtl/ft232h_xfer.sv
`default_nettype none
// ============================================================================
// Module   : ft232h_xfer
// Brief    : Host-side FT232H transaction sequencer. It pushes the address
//            bytes of a request into the TX FIFO, collects the response bytes
//            from the RX FIFO and presents them as one response word.
//            Optional macro FT232H_XFER_TIMEOUT_EN adds an RX idle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ft232h_xfer #(
    parameter int ADDR_BYTES  = 8,
    parameter int DATA_BYTES  = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [8*ADDR_BYTES-1:0] req_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [8*DATA_BYTES-1:0] rsp_data,
    output logic                    rsp_err,
    input  logic                    tx_full,
    output logic                    tx_wr_en,
    output logic [7:0]              tx_din,
    input  logic                    rx_empty,
    output logic                    rx_rd_en,
    input  logic [7:0]              rx_dout,
    output logic                    busy
);

    localparam int C_MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int C_CNT_W     = $clog2(C_MAX_BYTES + 1);
    localparam logic [C_CNT_W-1:0] C_TX_LAST = C_CNT_W'(ADDR_BYTES - 1);
    localparam logic [C_CNT_W-1:0] C_DATA_N  = C_CNT_W'(DATA_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_RECV = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                  state_q,    state_d;
    logic [8*ADDR_BYTES-1:0] addr_q,     addr_d;
    logic [C_CNT_W-1:0]      tx_cnt_q,   tx_cnt_d;
    logic [C_CNT_W-1:0]      iss_cnt_q,  iss_cnt_d;
    logic [C_CNT_W-1:0]      cap_cnt_q,  cap_cnt_d;
    logic                    pop_q,      pop_d;
    logic [8*DATA_BYTES-1:0] rsp_data_q, rsp_data_d;
    logic                    w_push;
    logic                    w_pop;

`ifdef FT232H_XFER_TIMEOUT_EN
    localparam int C_TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT_CYC - 1);

    logic [C_TO_W-1:0] to_cnt_q, to_cnt_d;
    logic              rsp_err_q, rsp_err_d;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC > 0);
`endif

    always_comb begin
        w_push     = (state_q == S_SEND) && !tx_full;
        w_pop      = (state_q == S_RECV) && !rx_empty && (iss_cnt_q < C_DATA_N);
        state_d    = state_q;
        addr_d     = addr_q;
        tx_cnt_d   = tx_cnt_q;
        iss_cnt_d  = iss_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        pop_d      = w_pop;
        rsp_data_d = rsp_data_q;
`ifdef FT232H_XFER_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        rsp_err_d  = rsp_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d    = S_SEND;
                    addr_d     = req_addr;
                    tx_cnt_d   = '0;
                    iss_cnt_d  = '0;
                    cap_cnt_d  = '0;
                    rsp_data_d = '0;
`ifdef FT232H_XFER_TIMEOUT_EN
                    to_cnt_d   = '0;
                    rsp_err_d  = 1'b0;
`endif
                end
            end
            S_SEND: begin
                // The address is shifted down so the next byte is always at [7:0].
                if (w_push) begin
                    addr_d   = addr_q >> 8;
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if (tx_cnt_q == C_TX_LAST) begin
                        state_d = S_RECV;
`ifdef FT232H_XFER_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end
                end
            end
            S_RECV: begin
                if (w_pop) begin
                    iss_cnt_d = iss_cnt_q + 1'b1;
                end
                // rx_dout carries the byte popped in the previous cycle.
                if (pop_q) begin
                    for (int i = 0; i < DATA_BYTES; i++) begin
                        if (cap_cnt_q == C_CNT_W'(i)) begin
                            rsp_data_d[8*i +: 8] = rx_dout;
                        end
                    end
                    cap_cnt_d = cap_cnt_q + 1'b1;
                end
                if (cap_cnt_q == C_DATA_N) begin
                    state_d = S_RESP;
                end
`ifdef FT232H_XFER_TIMEOUT_EN
                else if (pop_q) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == C_TO_LAST) begin
                    state_d   = S_RESP;
                    rsp_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            tx_cnt_q   <= '0;
            iss_cnt_q  <= '0;
            cap_cnt_q  <= '0;
            pop_q      <= 1'b0;
            rsp_data_q <= '0;
`ifdef FT232H_XFER_TIMEOUT_EN
            to_cnt_q   <= '0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tx_cnt_q   <= tx_cnt_d;
            iss_cnt_q  <= iss_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            pop_q      <= pop_d;
            rsp_data_q <= rsp_data_d;
`ifdef FT232H_XFER_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign tx_wr_en  = w_push;
    assign tx_din    = addr_q[7:0];
    assign rx_rd_en  = w_pop;
    assign rsp_data  = rsp_data_q;
`ifdef FT232H_XFER_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ft232h_xfer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ft232h_xfer
// Brief    : Self-checking bench for ft232h_xfer with behavioural TX/RX FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft232h_xfer;

    localparam int AB = 8;
    localparam int DB = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [63:0]   req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [63:0]   rsp_data;
    logic          rsp_err;
    logic          tx_full = 1'b0;
    logic          tx_wr_en;
    logic [7:0]    tx_din;
    logic          rx_empty = 1'b1;
    logic          rx_rd_en;
    logic [7:0]    rx_dout = '0;
    logic          busy;

    always #5 clk = ~clk;

    ft232h_xfer #(
        .ADDR_BYTES (AB),
        .DATA_BYTES (DB),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .tx_full  (tx_full),
        .tx_wr_en (tx_wr_en),
        .tx_din   (tx_din),
        .rx_empty (rx_empty),
        .rx_rd_en (rx_rd_en),
        .rx_dout  (rx_dout),
        .busy     (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural FIFOs: RX is a byte array with read pointer / fill limit,
    // TX is a log of every accepted push.
    logic [7:0] rx_mem [0:1023];
    int         rx_ptr = 0;
    int         rx_lim = 0;
    int         rx_mode = 0;
    bit         rx_tgl = 1'b0;
    logic [7:0] tx_log [$];
    int         tx_base = 0;
    int         tx_mode = 0;
    int         tx_since = 0;
    int         full_cnt = 0;
    int         tx_viol = 0;
    int         rx_viol = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (tx_wr_en) begin
                if (tx_full) tx_viol <= tx_viol + 1;
                else         tx_log.push_back(tx_din);
            end
            if (rx_rd_en) begin
                if (rx_empty) begin
                    rx_viol <= rx_viol + 1;
                end else begin
                    rx_dout <= rx_mem[rx_ptr % 1024];
                    rx_ptr  <= rx_ptr + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        tx_since = tx_log.size() - tx_base;
        if (tx_since < 3) full_cnt = 0;
        case (tx_mode)
            1: begin
                tx_full = (tx_since >= 3) && (full_cnt < 5);
                if (tx_full) full_cnt++;
            end
            2:       tx_full = ($urandom_range(0, 2) == 0);
            default: tx_full = 1'b0;
        endcase
        rx_tgl = ~rx_tgl;
        case (rx_mode)
            1:       rx_empty = (rx_ptr >= rx_lim) || rx_tgl;
            2:       rx_empty = (rx_ptr >= rx_lim) || ($urandom_range(0, 2) == 0);
            default: rx_empty = (rx_ptr >= rx_lim);
        endcase
    end

    // Loading starts at the current read pointer, discarding leftover bytes.
    task automatic rx_restart();
        rx_lim = rx_ptr;
    endtask

    task automatic rx_put(input logic [7:0] v);
        rx_mem[rx_lim % 1024] = v;
        rx_lim = rx_lim + 1;
    endtask

    // Drives one full transaction from a negedge and reports what it observed.
    task automatic run_xact(input logic [63:0] addr, input int hold, input bit keep_req,
                            input logic [63:0] next_addr, output int lat,
                            output logic [63:0] txw, output int ntx,
                            output logic [63:0] rspw, output logic err,
                            output int npop, output bit stable);
        int p0;
        int w;
        stable = 1'b1;
        lat    = -1;
        txw    = '0;
        rspw   = '0;
        err    = 1'b0;
        tx_base   = tx_log.size();
        p0        = rx_ptr;
        req_addr  = addr;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid) begin
                lat = c;
                break;
            end
        end
        if (lat > 0) begin
            rspw = rsp_data;
            err  = rsp_err;
            if (keep_req) begin
                req_valid = 1'b1;
                req_addr  = next_addr;
            end
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                if (!rsp_valid || rsp_data !== rspw || rsp_err !== err || req_ready)
                    stable = 1'b0;
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            if (rsp_valid || !req_ready || busy) stable = 1'b0;
        end
        ntx = tx_log.size() - tx_base;
        for (int i = 0; i < 8 && i < ntx; i++) txw[8*i +: 8] = tx_log[tx_base + i];
        npop = rx_ptr - p0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (tx_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_tx_wr_en: got %b want 0", tx_wr_en); end
        n_cmp++; if (rx_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rx_rd_en: got %b want 0", rx_rd_en); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (rsp_data !== 64'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, ntx, npop;
        logic [63:0] txw, rspw;
        logic err;
        bit st;
        tx_mode = 0; rx_mode = 0;
        rx_restart();
        for (int i = 0; i < 10; i++) rx_put(8'hA0 + 8'(i));
        run_xact(64'h0011_2233_4455_6677, 2, 1'b0, '0, lat, txw, ntx, rspw, err, npop, st);
        n_cmp++; if (lat !== 18) begin n_err++; $display("FAIL basic_latency: got %0d want 18", lat); end
        n_cmp++; if (ntx !== 8) begin n_err++; $display("FAIL basic_tx_count: got %0d want 8", ntx); end
        n_cmp++; if (txw !== 64'h0011_2233_4455_6677) begin n_err++; $display("FAIL basic_tx_bytes: got %h want 0011223344556677", txw); end
        n_cmp++; if (rspw !== 64'hA7A6_A5A4_A3A2_A1A0) begin n_err++; $display("FAIL basic_rsp_data: got %h want a7a6a5a4a3a2a1a0", rspw); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL basic_rsp_err: got %b want 0", err); end
        n_cmp++; if (npop !== 8) begin n_err++; $display("FAIL basic_pops: got %0d want 8", npop); end
        n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL basic_hold_stable: got %b want 1", st); end
    endtask

    task automatic test_tx_backpressure();
        int lat, ntx, npop;
        logic [63:0] txw, rspw, addr, exp;
        logic err;
        bit st;
        logic [7:0] b;
        tx_mode = 1; rx_mode = 0;
        addr = {$urandom, $urandom};
        exp  = '0;
        rx_restart();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            rx_put(b);
            exp = exp | (64'(b) << (8 * i));
        end
        run_xact(addr, 0, 1'b0, '0, lat, txw, ntx, rspw, err, npop, st);
        tx_mode = 0;
        n_cmp++; if (ntx !== 8) begin n_err++; $display("FAIL bp_tx_count: got %0d want 8", ntx); end
        n_cmp++; if (txw !== addr) begin n_err++; $display("FAIL bp_tx_bytes: got %h want %h", txw, addr); end
        n_cmp++; if (tx_viol !== 0) begin n_err++; $display("FAIL bp_push_while_full: got %0d want 0", tx_viol); end
        n_cmp++; if (lat !== 23) begin n_err++; $display("FAIL bp_latency: got %0d want 23", lat); end
        n_cmp++; if (rspw !== exp) begin n_err++; $display("FAIL bp_rsp_data: got %h want %h", rspw, exp); end
    endtask

    task automatic test_rx_starvation();
        int lat, ntx, npop;
        logic [63:0] txw, rspw, exp;
        logic err;
        bit st;
        logic [7:0] b;
        tx_mode = 0; rx_mode = 1;
        exp = '0;
        rx_restart();
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom_range(0, 255));
            rx_put(b);
            if (i < 8) exp = exp | (64'(b) << (8 * i));
        end
        run_xact(64'hDEAD_BEEF_0BAD_F00D, 1, 1'b0, '0, lat, txw, ntx, rspw, err, npop, st);
        rx_mode = 0;
        n_cmp++; if (npop !== 8) begin n_err++; $display("FAIL starve_pops: got %0d want 8", npop); end
        n_cmp++; if (rspw !== exp) begin n_err++; $display("FAIL starve_rsp_data: got %h want %h", rspw, exp); end
        n_cmp++; if (rx_viol !== 0) begin n_err++; $display("FAIL starve_pop_while_empty: got %0d want 0", rx_viol); end
    endtask

    task automatic test_resp_hold();
        int lat, ntx, npop;
        logic [63:0] txw, rspw, exp1, exp2, a2;
        logic err;
        bit st;
        logic [7:0] b;
        tx_mode = 0; rx_mode = 0;
        exp1 = '0; exp2 = '0;
        a2   = {$urandom, $urandom};
        rx_restart();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            rx_put(b);
            exp1 = exp1 | (64'(b) << (8 * i));
        end
        run_xact(64'h0123_4567_89AB_CDEF, 10, 1'b1, a2, lat, txw, ntx, rspw, err, npop, st);
        n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL hold_stable_no_early_accept: got %b want 1", st); end
        n_cmp++; if (rspw !== exp1) begin n_err++; $display("FAIL hold_rsp_data: got %h want %h", rspw, exp1); end
        rx_restart();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            rx_put(b);
            exp2 = exp2 | (64'(b) << (8 * i));
        end
        run_xact(a2, 0, 1'b0, '0, lat, txw, ntx, rspw, err, npop, st);
        n_cmp++; if (txw !== a2) begin n_err++; $display("FAIL hold_next_tx_bytes: got %h want %h", txw, a2); end
        n_cmp++; if (lat !== 18) begin n_err++; $display("FAIL hold_next_latency: got %0d want 18", lat); end
        n_cmp++; if (rspw !== exp2) begin n_err++; $display("FAIL hold_next_rsp_data: got %h want %h", rspw, exp2); end
    endtask

    task automatic test_reset_mid_recv();
        int lat, ntx, npop, p0, w;
        logic [63:0] txw, rspw, addr, exp;
        logic err;
        bit st;
        logic [7:0] b;
        tx_mode = 0; rx_mode = 0;
        rx_restart();
        for (int i = 0; i < 8; i++) rx_put(8'h10 + 8'(i));
        p0 = rx_ptr;
        req_addr  = 64'h5555_AAAA_5555_AAAA;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while ((rx_ptr - p0) < 3 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL midrst_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (rx_rd_en !== 1'b0) begin n_err++; $display("FAIL midrst_rx_rd_en: got %b want 0", rx_rd_en); end
        n_cmp++; if (rsp_data !== 64'h0) begin n_err++; $display("FAIL midrst_rsp_data: got %h want 0", rsp_data); end
        addr = {$urandom, $urandom};
        exp  = '0;
        rx_restart();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            rx_put(b);
            exp = exp | (64'(b) << (8 * i));
        end
        run_xact(addr, 0, 1'b0, '0, lat, txw, ntx, rspw, err, npop, st);
        n_cmp++; if (txw !== addr) begin n_err++; $display("FAIL midrst_next_tx_bytes: got %h want %h", txw, addr); end
        n_cmp++; if (rspw !== exp) begin n_err++; $display("FAIL midrst_next_rsp_data: got %h want %h", rspw, exp); end
        n_cmp++; if (lat !== 18) begin n_err++; $display("FAIL midrst_next_latency: got %0d want 18", lat); end
    endtask

    task automatic test_random();
        int lat, ntx, npop;
        logic [63:0] txw, rspw, addr, exp;
        logic err;
        bit st;
        logic [7:0] b;
        for (int k = 0; k < 6; k++) begin
            tx_mode = 2; rx_mode = 2;
            addr = {$urandom, $urandom};
            exp  = '0;
            rx_restart();
            for (int i = 0; i < 10; i++) begin
                b = 8'($urandom_range(0, 255));
                rx_put(b);
                if (i < 8) exp = exp | (64'(b) << (8 * i));
            end
            run_xact(addr, $urandom_range(0, 3), 1'b0, '0, lat, txw, ntx, rspw, err, npop, st);
            n_cmp++; if (txw !== addr || ntx !== 8) begin n_err++; $display("FAIL rand%0d_tx: got %h (%0d bytes) want %h (8 bytes)", k, txw, ntx, addr); end
            n_cmp++; if (rspw !== exp) begin n_err++; $display("FAIL rand%0d_rsp_data: got %h want %h", k, rspw, exp); end
            n_cmp++; if (npop !== 8) begin n_err++; $display("FAIL rand%0d_pops: got %0d want 8", k, npop); end
            n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL rand%0d_stable: got %b want 1", k, st); end
        end
        tx_mode = 0; rx_mode = 0;
        n_cmp++; if (tx_viol !== 0 || rx_viol !== 0) begin n_err++; $display("FAIL rand_fifo_protocol: got tx %0d rx %0d want 0 0", tx_viol, rx_viol); end
    endtask

`ifdef FT232H_XFER_TIMEOUT_EN
    task automatic test_timeout();
        int lat, ntx, npop;
        logic [63:0] txw, rspw;
        logic err;
        bit st;
        tx_mode = 0; rx_mode = 0;
        rx_restart();
        rx_put(8'h5A);
        rx_put(8'hC3);
        run_xact(64'h0F0E_0D0C_0B0A_0908, 2, 1'b0, '0, lat, txw, ntx, rspw, err, npop, st);
        n_cmp++; if (lat <= 0) begin n_err++; $display("FAIL timeout_rsp_valid: got latency %0d want a response", lat); end
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL timeout_rsp_err: got %b want 1", err); end
        n_cmp++; if (rspw !== 64'h0000_0000_0000_C35A) begin n_err++; $display("FAIL timeout_rsp_data: got %h want 000000000000c35a", rspw); end
        n_cmp++; if (npop !== 2) begin n_err++; $display("FAIL timeout_pops: got %0d want 2", npop); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_tx_backpressure();
        test_rx_starvation();
        test_resp_hold();
        test_reset_mid_recv();
        test_random();
`ifdef FT232H_XFER_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
